// File: rtl/wb_pkg.sv
// Shared writeback-path constants and index type.
// Requester slots and round-robin helper.
package wb_pkg;

    localparam int NREQ_MAX = 8;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    typedef logic [$clog2(NREQ_MAX)-1:0] req_idx_t;

    function automatic req_idx_t rr_next(
        input req_idx_t idx,
        input int       n
    );
        if (int'(idx) + 1 >= n) begin
            return '0;
        end
        return idx + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Shared by the writeback port and the memory port.
module rr_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] req,
    input  req_idx_t        ptr,
    output logic [NREQ-1:0] grant,
    output req_idx_t        idx,
    output logic            any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // Upper half of the ring (ptr..NREQ-1) has priority over the wrap.
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = req_idx_t'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[i]) begin
                any      = 1'b1;
                grant[i] = 1'b1;
                idx      = req_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter with RAW busy scoreboard.
// Optional WB_BYPASS_EN adds write-port bypass hits toward decode.
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    input  logic                 wb_stall,
    input  logic                 issue_vld,
    input  logic [AW-1:0]        issue_rd,
    input  logic [AW-1:0]        chk_rs1,
    input  logic [AW-1:0]        chk_rs2,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_add,
    output logic [XLEN-1:0]      wr_data
`ifdef WB_BYPASS_EN
    ,
    output logic                 byp1_hit,
    output logic                 byp2_hit,
    output logic [XLEN-1:0]      byp_data
`endif
);

    localparam int NREG = 1 << AW;

    req_idx_t        ptr_q, ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_add_q, wr_add_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [NREG-1:0] busy_q, busy_d;

    logic [NREQ-1:0] grant;
    req_idx_t        g_idx;
    logic            g_any;
    logic            xfer;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (g_idx),
        .any   (g_any)
    );

    // No grant is visible while stalled or held in reset.
    assign req_ready = grant & {NREQ{~wb_stall & rst}};
    assign xfer      = g_any & ~wb_stall & rst;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_add_d  = wr_add_q;
        wr_data_d = wr_data_q;
        if (xfer) begin
            ptr_d     = rr_next(g_idx, NREQ);
            wr_en_d   = (sel_addr != '0);
            wr_add_d  = sel_addr;
            wr_data_d = sel_data;
        end
    end

    // Set after clear: a newer producer of rd stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (xfer) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (issue_vld) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_add_q  <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_add_q  <= wr_add_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_add  = wr_add_q;
    assign wr_data = wr_data_q;

`ifdef WB_BYPASS_EN
    assign byp1_hit = wr_en_q & (wr_add_q == chk_rs1) & (chk_rs1 != '0);
    assign byp2_hit = wr_en_q & (wr_add_q == chk_rs2) & (chk_rs2 != '0);
    assign byp_data = wr_data_q;
    assign rs1_busy = busy_q[chk_rs1] & ~byp1_hit;
    assign rs2_busy = busy_q[chk_rs2] & ~byp2_hit;
`else
    assign rs1_busy = busy_q[chk_rs1];
    assign rs2_busy = busy_q[chk_rs2];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NREQ=3, XLEN=32, AW=5).
// Bypass checks are included when WB_BYPASS_EN is defined.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        wb_stall;
    logic        issue_vld;
    logic [4:0]  issue_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        wr_en;
    logic [4:0]  wr_add;
    logic [31:0] wr_data;
`ifdef WB_BYPASS_EN
    logic        byp1_hit;
    logic        byp2_hit;
    logic [31:0] byp_data;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .NREQ (3),
        .XLEN (32),
        .AW   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wb_stall  (wb_stall),
        .issue_vld (issue_vld),
        .issue_rd  (issue_rd),
        .chk_rs1   (chk_rs1),
        .chk_rs2   (chk_rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .wr_en     (wr_en),
        .wr_add    (wr_add),
        .wr_data   (wr_data)
`ifdef WB_BYPASS_EN
        ,
        .byp1_hit  (byp1_hit),
        .byp2_hit  (byp2_hit),
        .byp_data  (byp_data)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req_valid = 3'b111;
        req_addr[0 +: 5] = 5'd1;
        req_addr[5 +: 5] = 5'd2;
        req_addr[10 +: 5] = 5'd3;
        req_data[0 +: 32] = 32'd11;
        req_data[32 +: 32] = 32'd22;
        req_data[64 +: 32] = 32'd33;
        @(negedge clk);
        n_cmp++;
        if (req_ready !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_ready got=%b exp=000", req_ready);
        end
        n_cmp++;
        if (wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_wr_en got=%b exp=0", wr_en);
        end
        n_cmp++;
        if (wr_add !== 5'd0 || wr_data !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_wr_out got=%0d/%0d exp=0/0", wr_add, wr_data);
        end
        rst = 1'b1;
        issue_vld = 1'b1;
        issue_rd = 5'd7;
        chk_rs1 = 5'd7;
        #1;
        n_cmp++;
        if (req_ready !== 3'b001) begin
            n_bad++;
            $display("FAIL rst_first_grant got=%b exp=001", req_ready);
        end
        step();
        n_cmp++;
        if (wr_en !== 1'b1 || wr_add !== 5'd1 || rs1_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_rst_write got=%b/%0d/%b exp=1/1/1",
                     wr_en, wr_add, rs1_busy);
        end
        rst = 1'b0;
        issue_vld = 1'b0;
        #1;
        n_cmp++;
        if (wr_en !== 1'b0 || wr_add !== 5'd0 || wr_data !== 32'd0) begin
            n_bad++;
            $display("FAIL async_rst_out got=%b/%0d/%0d exp=0/0/0",
                     wr_en, wr_add, wr_data);
        end
        n_cmp++;
        if (req_ready !== 3'b000 || rs1_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst_rdy_busy got=%b/%b exp=000/0",
                     req_ready, rs1_busy);
        end
        step();
        n_cmp++;
        if (wr_en !== 1'b0 || req_ready !== 3'b000) begin
            n_bad++;
            $display("FAIL held_rst got=%b/%b exp=0/000", wr_en, req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 3'b001) begin
            n_bad++;
            $display("FAIL rst_ptr_zero got=%b exp=001", req_ready);
        end
        req_valid = 3'b000;
        step();
    endtask

    task automatic test_single();
        req_valid = 3'b010;
        req_addr[5 +: 5] = 5'd3;
        req_data[32 +: 32] = 32'd64;
        #1;
        n_cmp++;
        if (req_ready !== 3'b010) begin
            n_bad++;
            $display("FAIL single_ready got=%b exp=010", req_ready);
        end
        step();
        req_valid = 3'b000;
        n_cmp++;
        if (wr_en !== 1'b1 || wr_add !== 5'd3 || wr_data !== 32'd64) begin
            n_bad++;
            $display("FAIL single_write got=%b/%0d/%0d exp=1/3/64",
                     wr_en, wr_add, wr_data);
        end
        step();
        n_cmp++;
        if (wr_en !== 1'b0 || wr_add !== 5'd3) begin
            n_bad++;
            $display("FAIL single_idle got=%b/%0d exp=0/3", wr_en, wr_add);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g;
        req_valid = 3'b100;
        req_addr[10 +: 5] = 5'd9;
        req_data[64 +: 32] = 32'd9;
        step();
        n_cmp++;
        if (wr_en !== 1'b1 || wr_add !== 5'd9) begin
            n_bad++;
            $display("FAIL rr_prep got=%b/%0d exp=1/9", wr_en, wr_add);
        end
        req_addr[0 +: 5] = 5'd13;
        req_addr[5 +: 5] = 5'd14;
        req_addr[10 +: 5] = 5'd15;
        req_data[0 +: 32] = 32'h100;
        req_data[32 +: 32] = 32'h200;
        req_data[64 +: 32] = 32'h300;
        req_valid = 3'b111;
        for (int k = 0; k < 3; k++) begin
            exp_g = 3'b001 << k;
            #1;
            n_cmp++;
            if (req_ready !== exp_g) begin
                n_bad++;
                $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, exp_g);
            end
            step();
            n_cmp++;
            if (wr_en !== 1'b1 || wr_add !== 5'(13 + k) ||
                wr_data !== 32'(256 * (k + 1))) begin
                n_bad++;
                $display("FAIL rr_write%0d got=%b/%0d/%h exp=1/%0d/%h", k,
                         wr_en, wr_add, wr_data, 13 + k, 256 * (k + 1));
            end
        end
        req_valid = 3'b000;
    endtask

    task automatic test_scoreboard();
        logic exp_b;
        chk_rs1 = 5'd13;
        chk_rs2 = 5'd14;
        issue_vld = 1'b1;
        issue_rd = 5'd13;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_pre_set got=%b exp=0", rs1_busy);
        end
        step();
        issue_vld = 1'b0;
        n_cmp++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_set got=%b/%b exp=1/0", rs1_busy, rs2_busy);
        end
        step();
        req_valid = 3'b001;
        req_addr[0 +: 5] = 5'd13;
        req_data[0 +: 32] = 32'hAA;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || req_ready !== 3'b001) begin
            n_bad++;
            $display("FAIL sb_no_fwd got=%b/%b exp=1/001", rs1_busy, req_ready);
        end
        step();
        req_valid = 3'b000;
        n_cmp++;
        if (wr_en !== 1'b1 || wr_add !== 5'd13 || rs1_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_clear got=%b/%0d/%b exp=1/13/0",
                     wr_en, wr_add, rs1_busy);
        end
        issue_vld = 1'b1;
        step();
        req_valid = 3'b010;
        req_addr[5 +: 5] = 5'd13;
        req_data[32 +: 32] = 32'hBB;
        step();
        req_valid = 3'b000;
        issue_vld = 1'b0;
`ifdef WB_BYPASS_EN
        exp_b = 1'b0;
        n_cmp++;
        if (byp1_hit !== 1'b1 || byp_data !== 32'hBB) begin
            n_bad++;
            $display("FAIL sb_byp got=%b/%h exp=1/bb", byp1_hit, byp_data);
        end
`else
        exp_b = 1'b1;
`endif
        n_cmp++;
        if (wr_add !== 5'd13 || wr_data !== 32'hBB || rs1_busy !== exp_b) begin
            n_bad++;
            $display("FAIL sb_same_edge got=%0d/%h/%b exp=13/bb/%b",
                     wr_add, wr_data, rs1_busy, exp_b);
        end
        step();
        n_cmp++;
        if (wr_en !== 1'b0 || rs1_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL sb_set_wins got=%b/%b exp=0/1", wr_en, rs1_busy);
        end
        req_valid = 3'b100;
        req_addr[10 +: 5] = 5'd13;
        step();
        req_valid = 3'b000;
        step();
        n_cmp++;
        if (rs1_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sb_final_clear got=%b exp=0", rs1_busy);
        end
    endtask

    task automatic test_x0();
        chk_rs1 = 5'd0;
        req_valid = 3'b001;
        req_addr[0 +: 5] = 5'd0;
        req_data[0 +: 32] = 32'd50;
        issue_vld = 1'b1;
        issue_rd = 5'd0;
        #1;
        n_cmp++;
        if (req_ready !== 3'b001) begin
            n_bad++;
            $display("FAIL x0_ready got=%b exp=001", req_ready);
        end
        step();
        req_valid = 3'b000;
        issue_vld = 1'b0;
        n_cmp++;
        if (wr_en !== 1'b0 || rs1_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL x0_write got=%b/%b exp=0/0", wr_en, rs1_busy);
        end
        step();
        n_cmp++;
        if (rs1_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL x0_busy got=%b exp=0", rs1_busy);
        end
    endtask

    task automatic test_stall();
        req_valid = 3'b010;
        req_addr[5 +: 5] = 5'd5;
        req_data[32 +: 32] = 32'h55;
        step();
        n_cmp++;
        if (wr_en !== 1'b1 || wr_add !== 5'd5) begin
            n_bad++;
            $display("FAIL stall_prep got=%b/%0d exp=1/5", wr_en, wr_add);
        end
        req_valid = 3'b100;
        req_addr[10 +: 5] = 5'd21;
        req_data[64 +: 32] = 32'h77;
        wb_stall = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 3'b000) begin
            n_bad++;
            $display("FAIL stall_no_grant got=%b exp=000", req_ready);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++;
            if (wr_en !== 1'b0 || wr_add !== 5'd5 || wr_data !== 32'h55 ||
                req_ready !== 3'b000) begin
                n_bad++;
                $display("FAIL stall_hold%0d got=%b/%0d/%h/%b exp=0/5/55/000",
                         k, wr_en, wr_add, wr_data, req_ready);
            end
        end
        wb_stall = 1'b0;
        chk_rs1 = 5'd21;
        chk_rs2 = 5'd5;
        #1;
        n_cmp++;
        if (req_ready !== 3'b100) begin
            n_bad++;
            $display("FAIL stall_resume got=%b exp=100", req_ready);
        end
        step();
        req_valid = 3'b000;
        n_cmp++;
        if (wr_en !== 1'b1 || wr_add !== 5'd21 || wr_data !== 32'h77) begin
            n_bad++;
            $display("FAIL stall_write got=%b/%0d/%h exp=1/21/77",
                     wr_en, wr_add, wr_data);
        end
`ifdef WB_BYPASS_EN
        n_cmp++;
        if (byp1_hit !== 1'b1 || byp2_hit !== 1'b0 || byp_data !== 32'h77) begin
            n_bad++;
            $display("FAIL stall_byp got=%b/%b/%h exp=1/0/77",
                     byp1_hit, byp2_hit, byp_data);
        end
`endif
        step();
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        wb_stall = 1'b0;
        issue_vld = 1'b0;
        issue_rd = '0;
        chk_rs1 = '0;
        chk_rs2 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_scoreboard();
        test_x0();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
